// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state/op encodings and default sizes for the MULT/DIV sequencer
package mult_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;
  typedef enum logic {OP_MULT = 1'b0, OP_DIV = 1'b1} op_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;
endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one radix-2 Booth step or one restoring-division step, selected by op
module mult_div_step import mult_div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opb,
  input  logic             q1,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mq_n,
  output logic             q1_n
);
  logic [WIDTH:0] sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic ge;
  always_comb begin
    sum = {acc[WIDTH-1], acc} + ((mq[0] & ~q1) ? -{opb[WIDTH-1], opb} : (~mq[0] & q1) ? {opb[WIDTH-1], opb} : '0);
    rem_sh = {acc, mq[WIDTH-1]};
    ge = rem_sh >= {1'b0, opb};
    diff = rem_sh[WIDTH-1:0] - opb;
    acc_n = (op == OP_MULT) ? sum[WIDTH:1] : ge ? diff : rem_sh[WIDTH-1:0];
    mq_n = (op == OP_MULT) ? {sum[0], mq[WIDTH-1:1]} : {mq[WIDTH-2:0], ge};
    q1_n = (op == OP_MULT) ? mq[0] : 1'b0;
  end
endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: multicycle signed Booth multiply / restoring divide with HI/LO; MULTDIV_FAST_ZERO_EN skips CALC on zero operands
module mult_div_seq import mult_div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d, acc_s, mq_s;
  logic q1_q, q1_d, q1_s, neg_q, neg_d, sa_q, sa_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d, fast;
  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .op(op_q), .acc(acc_q), .mq(mq_q), .opb(opb_q), .q1(q1_q),
    .acc_n(acc_s), .mq_n(mq_s), .q1_n(q1_s)
  );
`ifdef MULTDIV_FAST_ZERO_EN
  assign fast = start_mult ? (a == '0 || b == '0) : (a == '0);
`else
  assign fast = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mq_d = mq_q;
    q1_d = q1_q;
    opb_d = opb_q;
    neg_d = neg_q;
    sa_d = sa_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_mult) begin
        state_d = fast ? FINISH : CALC;
        op_d = OP_MULT;
        cnt_d = '0;
        acc_d = '0;
        mq_d = fast ? '0 : b;
        q1_d = 1'b0;
        opb_d = a;
      end else if (start_div && b == '0) begin
        dz_d = 1'b1;
      end else if (start_div) begin
        state_d = fast ? FINISH : CALC;
        op_d = OP_DIV;
        cnt_d = '0;
        acc_d = '0;
        mq_d = a[WIDTH-1] ? -a : a;
        q1_d = 1'b0;
        opb_d = b[WIDTH-1] ? -b : b;
        sa_d = a[WIDTH-1];
        neg_d = a[WIDTH-1] ^ b[WIDTH-1];
      end
    end else if (state_q == CALC) begin
      acc_d = acc_s;
      mq_d = mq_s;
      q1_d = q1_s;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FINISH : CALC;
    end else begin
      hi_d = (op_q == OP_DIV && sa_q) ? -acc_q : acc_q;
      lo_d = (op_q == OP_DIV && neg_q) ? -mq_q : mq_q;
      done_d = 1'b1;
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= OP_MULT;
      cnt_q <= '0;
      acc_q <= '0;
      mq_q <= '0;
      q1_q <= 1'b0;
      opb_q <= '0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mq_q <= mq_d;
      q1_q <= q1_d;
      opb_q <= opb_d;
      neg_q <= neg_d;
      sa_q <= sa_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div_zero = dz_q;
endmodule
